// File: rtl/cpu_debug_unit_if.sv
// Board-side signal bundle of the debug unit: buttons/switches, CPU debug taps, LED/7-seg outputs.
interface cpu_debug_unit_if;
  logic        succ, step, m_rf, inc, dec;
  logic [2:0]  sel;
  logic [11:0] status;
  logic [31:0] m_data, rf_data, pc_in, pc_out, instr, rf_rd1, rf_rd2, alu_y, m_rd;
  logic        cpu_en;
  logic [7:0]  m_rf_addr;
  logic [15:0] led;
  logic [7:0]  an, seg;

  modport master (
    output succ, step, m_rf, inc, dec, sel, status,
    output m_data, rf_data, pc_in, pc_out, instr, rf_rd1, rf_rd2, alu_y, m_rd,
    input  cpu_en, m_rf_addr, led, an, seg
  );

  modport slave (
    input  succ, step, m_rf, inc, dec, sel, status,
    input  m_data, rf_data, pc_in, pc_out, instr, rf_rd1, rf_rd2, alu_y, m_rd,
    output cpu_en, m_rf_addr, led, an, seg
  );
endinterface

// File: rtl/cpu_debug_unit.sv
// Debug unit beside the single-cycle CPU: button conditioning, CPU clock enable,
// read-address counter, LED status and scanned 8-digit hex display.

// One conditioned input: 2-flop sync + debounce; EDGE=1 turns the level into a press pulse.
module cpu_debug_unit_db #(
  parameter int DB_CYCLES = 1_000_000,
  parameter bit EDGE      = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic out
);
  localparam int CW = $clog2(DB_CYCLES + 1);

  logic [1:0]    sync;
  logic [1:0]    vld_pipe;
  logic [CW-1:0] cnt;
  logic          level, level_q, arm;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync     <= '0;
      vld_pipe <= '0;
      cnt      <= '0;
      level    <= 1'b0;
      level_q  <= 1'b0;
      arm      <= 1'b0;
    end else begin
      sync     <= {sync[0], raw};
      vld_pipe <= {vld_pipe[0], 1'b1};
      // a button held through reset stays disarmed until it is seen released
      arm      <= arm | (vld_pipe[1] & ~sync[1]);
      level_q  <= level;
      if (sync[1] == level)
        cnt <= '0;
      else if (cnt == CW'(DB_CYCLES - 1)) begin
        cnt   <= '0;
        level <= sync[1];
      end else
        cnt <= cnt + CW'(1);
    end
  end

  assign out = EDGE ? (level & ~level_q & arm) : level;
endmodule

module cpu_debug_unit #(
  parameter int DB_CYCLES = 1_000_000,
  parameter int SCAN_DIV  = 100_000
) (
  input  logic             clk,
  input  logic             rst,
  cpu_debug_unit_if.slave  dbg
);
  localparam int SW = $clog2(SCAN_DIV + 1);

  // [0] step pulse, [1] inc pulse, [2] dec pulse, [3] succ level, [4] m_rf level
  logic [4:0]    raw, cond;
  logic          cpu_en;
  logic [7:0]    addr, an, seg;
  logic [15:0]   led;
  logic [SW-1:0] div;
  logic [2:0]    digit;
  logic [31:0]   v;

  assign raw = {dbg.m_rf, dbg.succ, dbg.dec, dbg.inc, dbg.step};

  for (genvar i = 0; i < 5; i++) begin : g_db
    cpu_debug_unit_db #(.DB_CYCLES(DB_CYCLES), .EDGE(i < 3)) u_db (
      .clk (clk),
      .rst (rst),
      .raw (raw[i]),
      .out (cond[i])
    );
  end

  always_comb begin
    v = 32'h0;
    case (dbg.sel)
      3'd0: v = cond[4] ? dbg.m_data : dbg.rf_data;
      3'd1: v = dbg.pc_in;
      3'd2: v = dbg.pc_out;
      3'd3: v = dbg.instr;
      3'd4: v = dbg.rf_rd1;
      3'd5: v = dbg.rf_rd2;
      3'd6: v = dbg.alu_y;
      default: v = dbg.m_rd;
    endcase
  end

  function automatic logic [7:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 8'hC0; 4'h1: glyph = 8'hF9; 4'h2: glyph = 8'hA4; 4'h3: glyph = 8'hB0;
      4'h4: glyph = 8'h99; 4'h5: glyph = 8'h92; 4'h6: glyph = 8'h82; 4'h7: glyph = 8'hF8;
      4'h8: glyph = 8'h80; 4'h9: glyph = 8'h90; 4'hA: glyph = 8'h88; 4'hB: glyph = 8'h83;
      4'hC: glyph = 8'hC6; 4'hD: glyph = 8'hA1; 4'hE: glyph = 8'h86; default: glyph = 8'h8E;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cpu_en <= 1'b0;
      addr   <= '0;
      led    <= '0;
      div    <= '0;
      digit  <= '0;
      an     <= 8'hFF;
      seg    <= 8'hFF;
    end else begin
      cpu_en <= cond[3] | cond[0];
      case ({cond[1], cond[2]})
        2'b10:   addr <= addr + 8'd1;
        2'b01:   addr <= addr - 8'd1;
        default: addr <= addr;
      endcase
      led <= (dbg.sel == 3'd0) ? {8'h00, addr} : {4'h0, dbg.status};
      // the digit pattern is refreshed once per slot, sampling V at that moment
      if (div == SW'(SCAN_DIV - 1)) begin
        div   <= '0;
        digit <= digit + 3'd1;
        an    <= ~(8'b1 << digit);
        seg   <= glyph(v[{digit, 2'b00} +: 4]);
      end else
        div <= div + SW'(1);
    end
  end

  assign dbg.cpu_en    = cpu_en;
  assign dbg.m_rf_addr = addr;
  assign dbg.led       = led;
  assign dbg.an        = an;
  assign dbg.seg       = seg;
endmodule

// File: tb/tb_cpu_debug_unit.sv
// Scoreboard bench for cpu_debug_unit: a cycle model pushes expected outputs, a monitor compares them.
module tb_cpu_debug_unit;
  localparam int DB = 4;
  localparam int SD = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  cpu_debug_unit_if dbg();

  cpu_debug_unit #(.DB_CYCLES(DB), .SCAN_DIV(SD)) dut (
    .clk (clk),
    .rst (rst),
    .dbg (dbg.slave)
  );

  typedef struct packed {
    logic        cpu_en;
    logic [7:0]  addr;
    logic [15:0] led;
    logic [7:0]  an;
    logic [7:0]  seg;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   errors = 0;

  logic [7:0] glyph [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                             8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  // reference state: per input, the raw samples taken at each clock since reset release
  bit         hist [5][$];
  bit         db [5];
  bit         rose [5];
  bit         seen0 [5];
  int         k;
  logic [7:0] m_addr, m_an, m_seg;

  function automatic bit raw_in(int i);
    case (i)
      0: return dbg.step;
      1: return dbg.inc;
      2: return dbg.dec;
      3: return dbg.succ;
      default: return dbg.m_rf;
    endcase
  endfunction

  function automatic bit samp(int i, int j);
    return (j >= 1) ? hist[i][j-1] : 1'b0;
  endfunction

  function automatic logic [31:0] view(bit mrf);
    case (dbg.sel)
      3'd0: return mrf ? dbg.m_data : dbg.rf_data;
      3'd1: return dbg.pc_in;
      3'd2: return dbg.pc_out;
      3'd3: return dbg.instr;
      3'd4: return dbg.rf_rd1;
      3'd5: return dbg.rf_rd2;
      3'd6: return dbg.alu_y;
      default: return dbg.m_rd;
    endcase
  endfunction

  task automatic model_reset();
    k = 0;
    for (int i = 0; i < 5; i++) begin
      hist[i].delete();
      db[i] = 0; rose[i] = 0; seen0[i] = 0;
    end
    m_addr = 8'h00; m_an = 8'hFF; m_seg = 8'hFF;
  endtask

  // Expected outputs after the coming rising edge, given the inputs now applied.
  task automatic model_edge(output exp_t e);
    bit stp, ip, dp, all;
    int dgt;
    logic [31:0] v;
    k++;
    for (int i = 0; i < 5; i++) hist[i].push_back(raw_in(i));
    stp = rose[0] && seen0[0];
    ip  = rose[1] && seen0[1];
    dp  = rose[2] && seen0[2];
    e.cpu_en = db[3] | stp;
    e.led    = (dbg.sel == 3'd0) ? {8'h00, m_addr} : {4'h0, dbg.status};
    if (ip && !dp) m_addr = m_addr + 8'd1;
    else if (dp && !ip) m_addr = m_addr - 8'd1;
    e.addr = m_addr;
    if (k % SD == 0) begin
      dgt   = ((k - 1) / SD) % 8;
      v     = view(db[4]);
      m_an  = ~(8'd1 << dgt);
      m_seg = glyph[v[4*dgt +: 4]];
    end
    e.an  = m_an;
    e.seg = m_seg;
    // a level flips once its last DB synchronised samples all disagree with it
    for (int i = 0; i < 5; i++) begin
      all = 1;
      for (int j = k - 1 - DB; j <= k - 2; j++)
        if (samp(i, j) == db[i]) all = 0;
      rose[i] = all && !db[i];
      if (all) db[i] = !db[i];
      if (k >= 3 && samp(i, k - 2) == 1'b0) seen0[i] = 1;
    end
  endtask

  task automatic advance();
    exp_t e;
    if (!rst) begin
      model_reset();
      e = '{cpu_en: 1'b0, addr: 8'h00, led: 16'h0000, an: 8'hFF, seg: 8'hFF};
    end else
      model_edge(e);
    expq.push_back(e);
  endtask

  task automatic hold(int n);
    repeat (n) begin
      @(negedge clk);
      advance();
    end
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      chk("cpu_en",    32'(dbg.cpu_en),    32'(e.cpu_en));
      chk("m_rf_addr", 32'(dbg.m_rf_addr), 32'(e.addr));
      chk("led",       32'(dbg.led),       32'(e.led));
      chk("an",        32'(dbg.an),        32'(e.an));
      chk("seg",       32'(dbg.seg),       32'(e.seg));
    end
  end

  task automatic rand_data();
    dbg.m_data = $urandom; dbg.rf_data = $urandom; dbg.pc_in = $urandom;
    dbg.pc_out = $urandom; dbg.instr = $urandom; dbg.rf_rd1 = $urandom;
    dbg.rf_rd2 = $urandom; dbg.alu_y = $urandom; dbg.m_rd = $urandom;
    dbg.status = 12'($urandom);
  endtask

  initial begin
    dbg.succ = 0; dbg.step = 0; dbg.m_rf = 0; dbg.inc = 0; dbg.dec = 0; dbg.sel = 3'd0;
    rand_data();
    model_reset();

    // reset held with random inputs
    repeat (5) begin
      @(negedge clk);
      dbg.step = 1'($urandom); dbg.inc = 1'($urandom); dbg.sel = 3'($urandom);
      advance();
    end
    @(negedge clk);
    dbg.step = 0; dbg.inc = 0; dbg.sel = 3'd1; rst = 1; advance();
    hold(6);

    // bounced step press
    @(negedge clk); dbg.step = 1; advance();
    @(negedge clk); dbg.step = 0; advance();
    @(negedge clk); dbg.step = 1; advance();
    hold(20);
    @(negedge clk); dbg.step = 0; advance();
    hold(10);

    // continuous run, step ignored
    @(negedge clk); dbg.succ = 1; advance();
    for (int c = 0; c < 30; c++) begin
      @(negedge clk); dbg.step = (c % 10) > 3; advance();
    end
    @(negedge clk); dbg.succ = 0; dbg.step = 0; advance();
    hold(12);

    // dec, inc, both together
    @(negedge clk); dbg.dec = 1; advance(); hold(10);
    @(negedge clk); dbg.dec = 0; advance(); hold(10);
    @(negedge clk); dbg.inc = 1; advance(); hold(10);
    @(negedge clk); dbg.inc = 0; advance(); hold(10);
    @(negedge clk); dbg.inc = 1; dbg.dec = 1; advance(); hold(10);
    @(negedge clk); dbg.inc = 0; dbg.dec = 0; advance(); hold(10);

    // instr display
    @(negedge clk); dbg.sel = 3'd3; dbg.instr = 32'h2008_0005; advance();
    hold(24);

    // memory view at address 5, then register file view
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); dbg.inc = 1; advance(); hold(8);
      @(negedge clk); dbg.inc = 0; advance(); hold(8);
    end
    @(negedge clk); dbg.sel = 3'd0; dbg.m_rf = 1; dbg.m_data = 32'hDEAD_BEEF; advance();
    hold(24);
    @(negedge clk); dbg.m_rf = 0; advance();
    hold(24);

    // reset with step held through release: no pulse until re-pressed
    @(negedge clk); dbg.step = 1; rst = 0; advance(); hold(2);
    @(negedge clk); rst = 1; advance(); hold(15);
    @(negedge clk); dbg.step = 0; advance(); hold(10);
    @(negedge clk); dbg.step = 1; advance(); hold(10);
    @(negedge clk); dbg.step = 0; advance(); hold(5);

    // random traffic with occasional resets
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 11) == 0) dbg.step = ~dbg.step;
      if ($urandom_range(0, 11) == 0) dbg.inc  = ~dbg.inc;
      if ($urandom_range(0, 11) == 0) dbg.dec  = ~dbg.dec;
      if ($urandom_range(0, 40) == 0) dbg.succ = ~dbg.succ;
      if ($urandom_range(0, 20) == 0) dbg.m_rf = ~dbg.m_rf;
      if ($urandom_range(0, 30) == 0) dbg.sel  = 3'($urandom);
      if ($urandom_range(0, 30) == 0) rand_data();
      if (!rst) rst = 1;
      else if ($urandom_range(0, 399) == 0) rst = 0;
      advance();
    end

    @(negedge clk);
    repeat (2) @(posedge clk);
    #2;
    chk("queue_drained", 32'(expq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
